// File: rtl/return_ctrl.sv
// Return-stack controller: turns CALL/RET/FLUSH into push/pop cycles.
// Define RS_FAULT_BLOCK_EN to suppress overflowing pushes and underflowing pops.
module return_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int DBITS = 7
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_addr,
  output logic [1:0]       stackOP,
  output logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] a,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_addr,
  output logic             resp_err,
  output logic [DBITS-1:0] depth,
  output logic             overflow,
  output logic             underflow
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_CALL  = 2'd1;
  localparam logic [1:0] OP_RET   = 2'd2;
  localparam logic [1:0] OP_FLUSH = 2'd3;

  localparam logic [1:0] SO_HOLD = 2'd0;
  localparam logic [1:0] SO_PUSH = 2'd1;
  localparam logic [1:0] SO_POP  = 2'd3;

  localparam logic [DBITS-1:0] DMAX = DBITS'(DEPTH);
  localparam logic [DBITS-1:0] DONE = DBITS'(1);

`ifdef RS_FAULT_BLOCK_EN
  localparam logic FB = 1'b1;
`else
  localparam logic FB = 1'b0;
`endif

  state_t     state;
  logic [1:0] op;
  logic       fault;
  logic       full;
  logic       empty;
  logic       call_blk;
  logic       ret_blk;

  assign full     = (depth == DMAX);
  assign empty    = (depth == '0);
  assign call_blk = FB & full;
  assign ret_blk  = FB & empty;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      op         <= OP_NOP;
      fault      <= 1'b0;
      cmd_ready  <= 1'b1;
      stackOP    <= SO_HOLD;
      w          <= '0;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
      depth      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ISSUE;
            cmd_ready <= 1'b0;
            op        <= cmd_op;
            fault     <= 1'b0;
            unique case (cmd_op)
              OP_CALL: begin
                fault   <= call_blk;
                stackOP <= call_blk ? SO_HOLD : SO_PUSH;
                w       <= call_blk ? '0 : cmd_addr;
              end
              OP_RET: begin
                fault     <= ret_blk;
                stackOP   <= ret_blk ? SO_HOLD : SO_POP;
                resp_addr <= ret_blk ? '0 : a;
              end
              OP_FLUSH: stackOP <= empty ? SO_HOLD : SO_POP;
              default:  stackOP <= SO_HOLD;
            endcase
          end
        end
        ISSUE: begin
          if (stackOP == SO_PUSH && !full)
            depth <= depth + DONE;
          if (stackOP == SO_POP && !empty)
            depth <= depth - DONE;
          if (op == OP_CALL && full)
            overflow <= 1'b1;
          if (op == OP_RET && empty)
            underflow <= 1'b1;
          // FLUSH keeps popping until this pop empties the stack
          if (!(op == OP_FLUSH && depth > DONE)) begin
            state      <= RESP;
            stackOP    <= SO_HOLD;
            w          <= '0;
            resp_valid <= 1'b1;
            resp_err   <= fault;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          cmd_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          stackOP   <= SO_HOLD;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_return_ctrl.sv
// Bench for return_ctrl: attached stack, directed tables, reference model.
// Works with or without RS_FAULT_BLOCK_EN.
module tb_return_ctrl;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_CALL  = 2'd1;
  localparam logic [1:0] OP_RET   = 2'd2;
  localparam logic [1:0] OP_FLUSH = 2'd3;

`ifdef RS_FAULT_BLOCK_EN
  localparam logic FB = 1'b1;
`else
  localparam logic FB = 1'b0;
`endif

  logic        CLK;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [1:0]  stackOP;
  logic [15:0] w;
  logic [15:0] a;
  logic        resp_valid;
  logic [15:0] resp_addr;
  logic        resp_err;
  logic [6:0]  depth;
  logic        overflow;
  logic        underflow;

  return_ctrl dut (
    .CLK(CLK), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .stackOP(stackOP), .w(w), .a(a),
    .resp_valid(resp_valid), .resp_addr(resp_addr),
    .resp_err(resp_err), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // attached 64-entry return stack: drops bottom on overflow, reads 0 when empty
  logic [15:0] mem [64];
  assign a = mem[0];
  always @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    end else if (stackOP == 2'd1) begin
      for (int i = 63; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= w;
    end else if (stackOP == 2'd3) begin
      for (int i = 0; i < 63; i++) mem[i] <= mem[i+1];
      mem[63] <= 16'h0;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // reference model: list of saved return addresses, newest first
  logic [15:0] refq[$];
  logic        ref_ovf;
  logic        ref_unf;
  logic [15:0] ref_ra;

  task automatic model_reset();
    refq.delete();
    ref_ovf = 1'b0;
    ref_unf = 1'b0;
    ref_ra  = 16'h0;
  endtask

  task automatic model_step(input logic [1:0] op, input logic [15:0] addr,
                            output logic [1:0] so, output int n,
                            output logic [15:0] ra, output logic err,
                            output int d);
    so  = 2'd0;
    n   = 0;
    err = 1'b0;
    ra  = ref_ra;
    case (op)
      OP_CALL: begin
        if (refq.size() == 64) begin
          ref_ovf = 1'b1;
          if (FB) err = 1'b1;
          else begin
            so = 2'd1; n = 1;
            refq.push_front(addr);
            void'(refq.pop_back());
          end
        end else begin
          so = 2'd1; n = 1;
          refq.push_front(addr);
        end
      end
      OP_RET: begin
        if (refq.size() == 0) begin
          ref_unf = 1'b1;
          ra = 16'h0;
          if (FB) err = 1'b1;
          else begin so = 2'd3; n = 1; end
        end else begin
          so = 2'd3; n = 1;
          ra = refq.pop_front();
        end
      end
      OP_FLUSH: begin
        n  = refq.size();
        so = (n > 0) ? 2'd3 : 2'd0;
        refq.delete();
      end
      default: ;
    endcase
    ref_ra = ra;
    d = refq.size();
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr,
                         input logic [1:0] exp_so, input int exp_n,
                         input logic [15:0] exp_ra, input logic exp_err,
                         input int exp_d, input logic exp_ovf,
                         input logic exp_unf);
    int t;
    int n;
    int cyc;
    t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge CLK);
      t++;
    end
    chk("ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_addr  = 16'($urandom);
    @(negedge CLK);
    chk("ready_low", cmd_ready, 0);
    chk("so_first", stackOP, exp_so);
    chk("w_push", w, (exp_so == 2'd1) ? addr : 16'h0);
    n = 0;
    cyc = 0;
    while (!resp_valid && cyc < 100) begin
      if (stackOP != 2'd0) begin
        n++;
        if (stackOP !== exp_so) chk("so_val", stackOP, exp_so);
      end
      cyc++;
      @(negedge CLK);
    end
    chk("resp_valid", resp_valid, 1);
    chk("active_cycles", n, exp_n);
    chk("latency", cyc, (exp_n > 1) ? exp_n : 1);
    chk("resp_addr", resp_addr, exp_ra);
    chk("resp_err", resp_err, exp_err);
    chk("depth", depth, exp_d);
    chk("overflow", overflow, exp_ovf);
    chk("underflow", underflow, exp_unf);
    chk("w_clear", w, 0);
    @(negedge CLK);
    chk("resp_pulse", resp_valid, 0);
    chk("ready_back", cmd_ready, 1);
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [15:0] addr);
    logic [1:0]  so;
    int          n;
    logic [15:0] ra;
    logic        err;
    int          d;
    model_step(op, addr, so, n, ra, err, d);
    run_cmd(op, addr, so, n, ra, err, d, ref_ovf, ref_unf);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [1:0]  so;
    int          n;
    logic [15:0] ra;
    int          d;
  } vec_t;

  vec_t tbl [8];

  logic [1:0]  bops  [7];
  logic [15:0] baddr [7];
  logic [15:0] bexp_ra[$];
  int          bexp_d[$];

  initial begin
    logic [1:0]  so;
    int          n;
    logic [15:0] ra;
    logic        err;
    int          d;
    int          nacc;
    int          nresp;
    int          last;
    int          cyc;
    int          r;
    logic [1:0]  op;

    tbl[0] = '{OP_CALL,  16'h0123, 2'd1, 1, 16'h0000, 1};
    tbl[1] = '{OP_RET,   16'h0000, 2'd3, 1, 16'h0123, 0};
    tbl[2] = '{OP_CALL,  16'h0002, 2'd1, 1, 16'h0123, 1};
    tbl[3] = '{OP_CALL,  16'h0004, 2'd1, 1, 16'h0123, 2};
    tbl[4] = '{OP_RET,   16'h0000, 2'd3, 1, 16'h0004, 1};
    tbl[5] = '{OP_RET,   16'h0000, 2'd3, 1, 16'h0002, 0};
    tbl[6] = '{OP_NOP,   16'h5555, 2'd0, 0, 16'h0002, 0};
    tbl[7] = '{OP_FLUSH, 16'haaaa, 2'd0, 0, 16'h0002, 0};

    bops[0] = OP_CALL; baddr[0] = 16'h0011;
    bops[1] = OP_CALL; baddr[1] = 16'h0022;
    bops[2] = OP_NOP;  baddr[2] = 16'h0099;
    bops[3] = OP_RET;  baddr[3] = 16'h0000;
    bops[4] = OP_CALL; baddr[4] = 16'h0033;
    bops[5] = OP_RET;  baddr[5] = 16'h0000;
    bops[6] = OP_RET;  baddr[6] = 16'h0000;

    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 16'h0;
    reset     = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_so", stackOP, 0);
    chk("rst_w", w, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_ra", resp_addr, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_depth", depth, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    reset = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 8; i++)
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].so, tbl[i].n, tbl[i].ra,
              1'b0, tbl[i].d, 1'b0, 1'b0);
    ref_ra = 16'h0002;

    for (int i = 0; i < 5; i++) model_cmd(OP_CALL, 16'(16'h0100 + i));
    model_cmd(OP_FLUSH, 16'h0);
    chk("flush_depth", depth, 0);

    for (int i = 1; i <= 65; i++) model_cmd(OP_CALL, 16'(i));
    chk("full_depth", depth, 64);
    chk("full_ovf", overflow, 1);
    for (int i = 0; i < 64; i++) model_cmd(OP_RET, 16'h0);
    chk("ret64_addr", resp_addr, FB ? 16'h0001 : 16'h0002);
    chk("ret64_unf", underflow, 0);
    model_cmd(OP_RET, 16'h0);
    chk("uflow_addr", resp_addr, 0);
    chk("uflow_flag", underflow, 1);
    model_cmd(OP_FLUSH, 16'h0);
    chk("flush_keeps_ovf", overflow, 1);
    chk("flush_keeps_unf", underflow, 1);

    for (int i = 0; i < 3; i++) model_cmd(OP_CALL, 16'(16'h0700 + i));
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_op    = OP_RET;
    @(posedge CLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge CLK);
    chk("abort_issue_so", stackOP, 3);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("abort_so", stackOP, 0);
    chk("abort_rv", resp_valid, 0);
    chk("abort_depth", depth, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_unf", underflow, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_ra", resp_addr, 0);
    @(negedge CLK);
    chk("abort_rv2", resp_valid, 0);

    nacc  = 0;
    nresp = 0;
    last  = -1;
    cyc   = 0;
    while (nacc < 7 && cyc < 60) begin
      if (resp_valid) begin
        nresp++;
        if (bexp_ra.size() > 0) begin
          chk("b2b_addr", resp_addr, bexp_ra.pop_front());
          chk("b2b_depth", depth, bexp_d.pop_front());
        end
      end
      if (cmd_ready) begin
        if (last >= 0) chk("b2b_gap", cyc - last, 3);
        last      = cyc;
        cmd_valid = 1'b1;
        cmd_op    = bops[nacc];
        cmd_addr  = baddr[nacc];
        model_step(bops[nacc], baddr[nacc], so, n, ra, err, d);
        bexp_ra.push_back(ra);
        bexp_d.push_back(d);
        nacc++;
      end
      @(negedge CLK);
      cyc++;
    end
    cmd_valid = 1'b0;
    repeat (4) begin
      if (resp_valid) begin
        nresp++;
        if (bexp_ra.size() > 0) begin
          chk("b2b_addr", resp_addr, bexp_ra.pop_front());
          chk("b2b_depth", depth, bexp_d.pop_front());
        end
      end
      @(negedge CLK);
    end
    chk("b2b_accepts", nacc, 7);
    chk("b2b_resps", nresp, 7);

    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 99));
      op = (r < 40) ? OP_CALL : (r < 75) ? OP_RET :
           (r < 88) ? OP_NOP : OP_FLUSH;
      model_cmd(op, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
